instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: assembles 16-bit words (plus jump immediates), queues them
// in a 4-deep FIFO and issues spaced we_IM writes to the CPU. Optional LOADER_CHKSUM_EN adds a trailing XOR check byte.
module instr_loader #(
    parameter logic [3:0]  JMP_OP   = 4'h7,
    parameter logic [15:0] END_CODE = 16'hFFFF,
    parameter int          GAP      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        we_IM,
    output logic [15:0] codein,
    output logic [11:0] immd,
    output logic        cpu_en,
    output logic        busy,
    output logic        err
);

`ifdef LOADER_CHKSUM_EN
    typedef enum logic [2:0] {P_HI, P_LO, P_IH, P_IL, P_CK, P_DONE} pstate_t;
`else
    typedef enum logic [2:0] {P_HI, P_LO, P_IH, P_IL, P_DONE} pstate_t;
`endif
    typedef enum logic [1:0] {I_IDLE, I_WRITE, I_GAP} istate_t;

    localparam logic [3:0] GAP_M1 = 4'(GAP - 1);

    pstate_t     pstate_q, pstate_d;
    istate_t     istate_q, istate_d;
    logic [15:0] code_q, code_d;
    logic [3:0]  imm_hi_q, imm_hi_d;
    logic        err_q, err_d;
    logic [15:0] codein_q, codein_d;
    logic [11:0] immd_q, immd_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        cpu_en_q, cpu_en_d;
`ifdef LOADER_CHKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    // FIFO entry: {code[15:0], imm[11:0], jmp}
    logic [28:0] mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  cnt_q;
    logic        push, pop, full, empty, accept;
    logic [28:0] push_data, head;
    logic [15:0] word;

    assign full     = (cnt_q == 3'd4);
    assign empty    = (cnt_q == 3'd0);
    assign rx_ready = !rst && !full && (pstate_q != P_DONE) && !err_q;
    assign accept   = rx_valid && rx_ready;
    assign word     = {code_q[15:8], rx_data};
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        pstate_d  = pstate_q;
        code_d    = code_q;
        imm_hi_d  = imm_hi_q;
        err_d     = err_q;
        push      = 1'b0;
        push_data = {code_q, 12'h000, 1'b0};
`ifdef LOADER_CHKSUM_EN
        chk_d     = chk_q;
        if (accept && pstate_q != P_CK)
            chk_d = chk_q ^ rx_data;
`endif
        case (pstate_q)
            P_HI: if (accept) begin
                code_d[15:8] = rx_data;
                pstate_d     = P_LO;
            end
            P_LO: if (accept) begin
                code_d[7:0] = rx_data;
                if (word == END_CODE) begin
`ifdef LOADER_CHKSUM_EN
                    pstate_d = P_CK;
`else
                    pstate_d = P_DONE;
`endif
                end else if (word[15:12] == JMP_OP) begin
                    pstate_d = P_IH;
                end else begin
                    push      = 1'b1;
                    push_data = {word, 12'h000, 1'b0};
                    pstate_d  = P_HI;
                end
            end
            P_IH: if (accept) begin
                // Immediate is 12 bits; any upper-nibble bit means a corrupt frame.
                if (rx_data[7:4] != 4'h0) begin
                    err_d    = 1'b1;
                    pstate_d = P_DONE;
                end else begin
                    imm_hi_d = rx_data[3:0];
                    pstate_d = P_IL;
                end
            end
            P_IL: if (accept) begin
                push      = 1'b1;
                push_data = {code_q, imm_hi_q, rx_data, 1'b1};
                pstate_d  = P_HI;
            end
`ifdef LOADER_CHKSUM_EN
            P_CK: if (accept) begin
                if (rx_data != chk_q)
                    err_d = 1'b1;
                pstate_d = P_DONE;
            end
`endif
            default: pstate_d = pstate_q;
        endcase
    end

    always_comb begin
        istate_d  = istate_q;
        gap_cnt_d = gap_cnt_q;
        codein_d  = codein_q;
        immd_d    = immd_q;
        // The last gap cycle may pop directly so pulses are exactly GAP+1 apart.
        pop = !empty && (istate_q == I_IDLE || (istate_q == I_GAP && gap_cnt_q == 4'd0));
        if (pop) begin
            istate_d = I_WRITE;
            codein_d = head[28:13];
            if (head[0])
                immd_d = head[12:1];
        end else begin
            case (istate_q)
                I_WRITE: begin
                    istate_d  = I_GAP;
                    gap_cnt_d = GAP_M1;
                end
                I_GAP: begin
                    if (gap_cnt_q == 4'd0)
                        istate_d = I_IDLE;
                    else
                        gap_cnt_d = gap_cnt_q - 4'd1;
                end
                default: istate_d = istate_q;
            endcase
        end
        cpu_en_d = cpu_en_q || (pstate_q == P_DONE && !err_q && empty && istate_q == I_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate_q  <= P_HI;
            istate_q  <= I_IDLE;
            code_q    <= 16'h0000;
            imm_hi_q  <= 4'h0;
            err_q     <= 1'b0;
            codein_q  <= 16'h0000;
            immd_q    <= 12'h000;
            gap_cnt_q <= 4'd0;
            cpu_en_q  <= 1'b0;
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            cnt_q     <= 3'd0;
            for (int i = 0; i < 4; i++)
                mem_q[i] <= 29'd0;
`ifdef LOADER_CHKSUM_EN
            chk_q     <= 8'h00;
`endif
        end else begin
            pstate_q  <= pstate_d;
            istate_q  <= istate_d;
            code_q    <= code_d;
            imm_hi_q  <= imm_hi_d;
            err_q     <= err_d;
            codein_q  <= codein_d;
            immd_q    <= immd_d;
            gap_cnt_q <= gap_cnt_d;
            cpu_en_q  <= cpu_en_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 2'd1;
            cnt_q <= cnt_q + 3'(push) - 3'(pop);
`ifdef LOADER_CHKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    assign we_IM  = (istate_q == I_WRITE);
    assign codein = codein_q;
    assign immd   = immd_q;
    assign cpu_en = cpu_en_q;
    assign busy   = !empty || (istate_q != I_IDLE);
    assign err    = err_q;

endmodule
